// File: rtl/bisection_ctrl.sv
// Bisection root-search controller: computes midpoints with an external serial adder,
// hands each midpoint to an f(x) evaluator over req/ack and reports the bracketed root.
// States: IDLE wait start | LOAD pulse adder | ADD_WAIT let adder finish | EVAL await f_ack
//         UPDATE close-or-continue check | DONE one-cycle completion pulse
module bisection_ctrl #(
    parameter int ADD_CYCLES = 9,
    parameter int MAX_ITER   = 8,
    parameter int F_TIMEOUT  = 255
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] lo_in,
    input  logic [7:0] hi_in,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] root,
    output logic [3:0] iters,
    output logic       add_load,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    input  logic [7:0] add_sum,
    output logic       f_req,
    output logic [7:0] f_x,
    input  logic       f_ack,
    input  logic       f_pos,
    input  logic       f_zero
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD_WAIT,
        S_EVAL,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_lo, r_hi, r_mid, r_root;
    logic [7:0] w_lo_nxt, w_hi_nxt, w_mid_nxt, w_root_nxt;
    logic [3:0] r_iters, w_iters_nxt;
    logic       r_err, w_err_nxt;
    logic [7:0] r_wcnt, w_wcnt_nxt;
    logic [7:0] r_tcnt, w_tcnt_nxt;
    logic [7:0] w_span_in;
    logic [7:0] w_span;

    assign w_span_in = hi_in - lo_in;
    assign w_span    = r_hi - r_lo;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_lo    <= 8'd0;
            r_hi    <= 8'd0;
            r_mid   <= 8'd0;
            r_root  <= 8'd0;
            r_iters <= 4'd0;
            r_err   <= 1'b0;
            r_wcnt  <= 8'd0;
            r_tcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_mid   <= w_mid_nxt;
            r_root  <= w_root_nxt;
            r_iters <= w_iters_nxt;
            r_err   <= w_err_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_mid_nxt   = r_mid;
        w_root_nxt  = r_root;
        w_iters_nxt = r_iters;
        w_err_nxt   = r_err;
        w_wcnt_nxt  = r_wcnt;
        w_tcnt_nxt  = r_tcnt;
        busy        = 1'b1;
        done        = 1'b0;
        add_load    = 1'b0;
        f_req       = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_err_nxt   = 1'b0;
                    w_iters_nxt = 4'd0;
                    w_lo_nxt    = lo_in;
                    w_hi_nxt    = hi_in;
                    if (lo_in > hi_in) begin
                        w_err_nxt   = 1'b1;
                        w_root_nxt  = 8'd0;
                        w_state_nxt = S_DONE;
                    end else if (w_span_in <= 8'd1) begin
                        w_root_nxt  = lo_in;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                add_load    = 1'b1;
                w_wcnt_nxt  = 8'(ADD_CYCLES);
                w_state_nxt = S_ADD_WAIT;
            end
            S_ADD_WAIT: begin
                w_wcnt_nxt = r_wcnt - 8'd1;
                if (r_wcnt <= 8'd1) begin
                    // Halved operands drop both LSBs; add the carry they would have made.
                    w_mid_nxt   = add_sum + {7'd0, r_lo[0] & r_hi[0]};
                    w_tcnt_nxt  = 8'd0;
                    w_state_nxt = S_EVAL;
                end
            end
            S_EVAL: begin
                f_req = 1'b1;
                if (f_ack) begin
                    w_iters_nxt = r_iters + 4'd1;
                    if (f_zero) begin
                        w_root_nxt  = r_mid;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_DONE;
                    end else if (f_pos) begin
                        w_hi_nxt    = r_mid;
                        w_state_nxt = S_UPDATE;
                    end else begin
                        w_lo_nxt    = r_mid;
                        w_state_nxt = S_UPDATE;
                    end
                end else if (r_tcnt >= 8'(F_TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_root_nxt  = r_lo;
                    w_state_nxt = S_DONE;
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            S_UPDATE: begin
                if (w_span <= 8'd1 || r_iters == 4'(MAX_ITER)) begin
                    w_root_nxt  = r_lo;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign err   = r_err;
    assign root  = r_root;
    assign iters = r_iters;
    assign add_a = {1'b0, r_lo[7:1]};
    assign add_b = {1'b0, r_hi[7:1]};
    assign f_x   = r_mid;

endmodule
